// File: rtl/scan_counter_display.sv
// scan_counter_display: N-digit hex/BCD up/down counter with a time-multiplexed,
// common-segment 7-segment display driver. Everything runs in the clk domain
// with a synchronous active-low reset.
// Optional build macro SCAN_COUNTER_DISPLAY_LZB_EN adds leading-zero blanking.
module scan_counter_display #(
    parameter int DIGITS   = 4,
    parameter int CLK_HZ   = 50000000,
    parameter int COUNT_HZ = 1,
    parameter int SCAN_HZ  = 1000,
    parameter int BCD      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_en
);

    localparam int VW        = 4 * DIGITS;
    localparam int COUNT_DIV = CLK_HZ / COUNT_HZ;
    localparam int SCAN_DIV  = CLK_HZ / (SCAN_HZ * DIGITS);
    localparam int CNT_W     = (COUNT_DIV > 2) ? $clog2(COUNT_DIV) : 1;
    localparam int SCN_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0] DIGIT_MAX = (BCD != 0) ? 4'd9 : 4'd15;

    // 7-segment pattern {a,b,c,d,e,f,g} for one nibble
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0: seg_decode = 7'b1111110;
            4'h1: seg_decode = 7'b0110000;
            4'h2: seg_decode = 7'b1101101;
            4'h3: seg_decode = 7'b1111001;
            4'h4: seg_decode = 7'b0110011;
            4'h5: seg_decode = 7'b1011011;
            4'h6: seg_decode = 7'b1011111;
            4'h7: seg_decode = 7'b1110000;
            4'h8: seg_decode = 7'b1111111;
            4'h9: seg_decode = 7'b1111011;
            4'hA: seg_decode = 7'b1110111;
            4'hB: seg_decode = 7'b0011111;
            4'hC: seg_decode = 7'b1001110;
            4'hD: seg_decode = 7'b0111101;
            4'hE: seg_decode = 7'b1001111;
            default: seg_decode = 7'b1000111;
        endcase
    endfunction

    logic [CNT_W-1:0] count_cnt;
    logic             count_tick;
    logic [SCN_W-1:0] scan_cnt;
    logic             scan_tick;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] shown_idx;
    logic [IDX_W-1:0] src_idx;
    logic [3:0]       src_nibble;
    logic             blank;
    logic [VW-1:0]    inc_value;
    logic [VW-1:0]    dec_value;
    logic             inc_carry;
    logic             dec_borrow;

    assign count_tick = (count_cnt == CNT_W'(COUNT_DIV - 1));
    assign scan_tick  = (scan_cnt == SCN_W'(SCAN_DIV - 1));

    // Free-running count prescaler, independent of run
    always_ff @(posedge clk) begin
        if (!rst_n || count_tick) count_cnt <= '0;
        else                      count_cnt <= count_cnt + 1'b1;
    end

    // Ripple carry/borrow over the digits; above-max BCD digits roll to 0 on up
    always_comb begin
        inc_value  = value;
        dec_value  = value;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_carry) begin
                if (value[4*i +: 4] >= DIGIT_MAX) begin
                    inc_value[4*i +: 4] = 4'd0;
                end else begin
                    inc_value[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    inc_carry = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (value[4*i +: 4] == 4'd0) begin
                    dec_value[4*i +: 4] = DIGIT_MAX;
                end else begin
                    dec_value[4*i +: 4] = value[4*i +: 4] - 4'd1;
                    dec_borrow = 1'b0;
                end
            end
        end
    end

    // Counter register: clear beats load beats a running tick; wrap only on counting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (clear) begin
                value <= '0;
            end else if (load) begin
                value <= load_value;
            end else if (count_tick && run) begin
                value <= up ? inc_value : dec_value;
                wrap  <= up ? inc_carry : dec_borrow;
            end
        end
    end

    // Scan prescaler sets the per-digit slot length
    always_ff @(posedge clk) begin
        if (!rst_n || scan_tick) scan_cnt <= '0;
        else                     scan_cnt <= scan_cnt + 1'b1;
    end

    // scan_idx is the digit for the next slot; shown_idx the digit now enabled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_idx  <= '0;
            shown_idx <= '0;
        end else if (scan_tick) begin
            shown_idx <= scan_idx;
            scan_idx  <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    assign src_idx    = scan_tick ? scan_idx : shown_idx;
    assign src_nibble = value[{src_idx, 2'b00} +: 4];

`ifdef SCAN_COUNTER_DISPLAY_LZB_EN
    // Blank a non-zero position when it and every digit above it are zero
    always_comb begin
        blank = (src_idx != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(src_idx) && value[4*i +: 4] != 4'd0) blank = 1'b0;
        end
    end
`else
    assign blank = 1'b0;
`endif

    // Registered display outputs: dark until the first scan slot, then one-hot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dig_en <= '0;
            seg    <= '0;
        end else begin
            if (scan_tick) dig_en <= DIGITS'(1) << scan_idx;
            if (scan_tick || (|dig_en)) seg <= blank ? 7'd0 : seg_decode(src_nibble);
        end
    end

endmodule
